inst_fetch_queue: RTL and testbench



---
 rtl/inst_fetch_queue.sv | 121 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH x {pc, inst} FIFO with one-cycle flush.
// Optional same-cycle empty-queue bypass when FETCHQ_BYPASS_EN is defined.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PC_WIDTH = 32,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      enq_valid,
  output logic                      enq_ready,
  input  logic [PC_WIDTH-1:0]       enq_pc,
  input  logic [31:0]               enq_inst,
  output logic                      deq_valid,
  input  logic                      deq_ready,
  output logic [PC_WIDTH-1:0]       deq_pc,
  output logic [31:0]               deq_inst,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [PC_WIDTH-1:0] r_mem_pc   [DEPTH];
  logic [31:0]         r_mem_inst [DEPTH];
  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic [AW:0]         r_count;
  logic [AW:0]         w_count_nxt;
  logic                w_full;
  logic                w_empty;
  logic                w_enq_fire;
  logic                w_enq_write;
  logic                w_deq_pop;
  logic                w_bypass;
  logic                w_bypass_take;
  logic [PC_WIDTH-1:0] w_deq_pc;
  logic [31:0]         w_deq_inst;

  // MSB of each pointer is the wrap bit; DEPTH is a power of two so +1 toggles it.
  assign w_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_enq_fire = enq_valid && !w_full;
`ifdef FETCHQ_BYPASS_EN
  assign w_bypass   = w_empty && enq_valid && !flush;
`else
  assign w_bypass   = 1'b0;
`endif
  assign w_bypass_take = w_bypass && deq_ready;
  assign w_enq_write   = w_enq_fire && !w_bypass_take;
  assign w_deq_pop     = !w_empty && deq_ready;

  // Occupancy update from the write/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_enq_write, w_deq_pop})
      2'b10:   w_count_nxt = r_count + PTR_ONE;
      2'b01:   w_count_nxt = r_count - PTR_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Head selection: stored entry, bypassed enqueue, or NOP when nothing is valid.
  always_comb begin
    w_deq_pc   = {PC_WIDTH{1'b0}};
    w_deq_inst = NOP_INST;
    if (!w_empty) begin
      w_deq_pc   = r_mem_pc[r_rd_ptr[AW-1:0]];
      w_deq_inst = r_mem_inst[r_rd_ptr[AW-1:0]];
    end else begin
`ifdef FETCHQ_BYPASS_EN
      if (w_bypass) begin
        w_deq_pc   = enq_pc;
        w_deq_inst = enq_inst;
      end else begin
        w_deq_pc   = {PC_WIDTH{1'b0}};
        w_deq_inst = NOP_INST;
      end
`else
      w_deq_pc   = {PC_WIDTH{1'b0}};
      w_deq_inst = NOP_INST;
`endif
    end
  end

  // Pointer and count state; flush outranks any handshake in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else if (flush) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_enq_write) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_deq_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
    end
  end

  // Entry storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_enq_write && !flush) begin
      r_mem_pc[r_wr_ptr[AW-1:0]]   <= enq_pc;
      r_mem_inst[r_wr_ptr[AW-1:0]] <= enq_inst;
    end
  end

  assign enq_ready = !w_full;
  assign deq_valid = !w_empty || w_bypass;
  assign deq_pc    = w_deq_pc;
  assign deq_inst  = w_deq_inst;
  assign count     = r_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed plan items followed by random traffic,
// checked against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_inst;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  bit cyc_acc;
  bit cyc_byp_take;

  inst_fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_inst(enq_inst),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc), .deq_inst(deq_inst),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs to the model mid-cycle and pops on a dequeue.
  initial begin
    forever begin
      bit          exp_v;
      bit          byp_cond;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      @(negedge clk);
      #2;
      byp_cond = BYP && (exp_q.size() == 0) && enq_valid && !flush && !reset;
      exp_v    = (exp_q.size() > 0) || byp_cond;
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("enq_ready", 64'(enq_ready), 64'(exp_q.size() < DEPTH));
      chk("deq_valid", 64'(deq_valid), 64'(exp_v));
      if (exp_q.size() > 0) begin
        e_pc   = exp_q[0][63:32];
        e_inst = exp_q[0][31:0];
      end else if (byp_cond) begin
        e_pc   = enq_pc;
        e_inst = enq_inst;
      end else begin
        e_pc   = 32'h0;
        e_inst = NOP;
      end
      chk("deq_pc", 64'(deq_pc), 64'(e_pc));
      chk("deq_inst", 64'(deq_inst), 64'(e_inst));
      if (exp_v && deq_ready && !flush && !reset && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // One driven cycle: inputs at the falling edge, model commit after the rising edge.
  task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                       input bit rdy, input bit fl);
    @(negedge clk);
    enq_valid = v;
    enq_pc    = pc;
    enq_inst  = inst;
    deq_ready = rdy;
    flush     = fl;
    cyc_acc      = v && (exp_q.size() < DEPTH) && !fl;
    cyc_byp_take = BYP && cyc_acc && (exp_q.size() == 0) && rdy;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else if (cyc_acc && !cyc_byp_take) begin
      exp_q.push_back({pc, inst});
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_pc = 32'h0; enq_inst = 32'h0;
    #23 reset = 1'b0;

    // Fill, reject a fifth entry, then drain in order.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h100 + 32'(i) * 32'd4, 32'h00500093 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Wrap-around with continuous traffic.
    cycle(1'b1, 32'h400, 32'h11100093, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++)
      cycle(1'b1, 32'h400 + 32'(i) * 32'd4, 32'h11100093 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Simultaneous enq/deq at full.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h500 + 32'(i) * 32'd4, 32'h22200093 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h510, 32'h222000ff, 1'b1, 1'b0);
    cycle(1'b1, 32'h514, 32'h22200fff, 1'b0, 1'b0);

    // Flush with count 3 plus enq and deq in the same cycle.
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h600, 32'h33300093, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h200, 32'h44400093, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset between edges with count 2.
    cycle(1'b1, 32'h700, 32'h55500093, 1'b0, 1'b0);
    cycle(1'b1, 32'h704, 32'h55500094, 1'b0, 1'b0);
    enq_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("async_rst_deq_inst", 64'(deq_inst), 64'(NOP));
    exp_q.delete();
    #1 reset = 1'b0;

    // Empty-queue enqueue with deq_ready high (bypass or one-cycle latency).
    cycle(1'b1, 32'h300, 32'h66600093, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h304, 32'h66600094, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic, including arbitrary instruction words.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom & 32'hfffffffc, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
